// File: rtl/gfp8_bcv_pkg.sv
// Shared types and constants for the GFP8 block dot-product path.
package gfp8_bcv_pkg;

   localparam int MANT_W   = 8;
   localparam int EXP_W    = 5;
   localparam int EXP_BIAS = 15;
   localparam int DOUT_W   = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Result of one block dot product: integer mantissa sum plus combined exponent.
   typedef struct packed {
      logic signed [DOUT_W-1:0] mant;
      logic signed [EXP_W+1:0]  exp;
   } gfp8_res_t;

endpackage

// File: rtl/gfp8_dot_sequencer.sv
// Drives an external accumulate-mode integer MAC through one GFP8 block dot product:
// takes a command, streams operand beats, waits out the MAC pipeline, returns the sum.
module gfp8_dot_sequencer #(
   parameter int NUM_MULT = 32,
   parameter int MANT_W   = gfp8_bcv_pkg::MANT_W,
   parameter int EXP_W    = gfp8_bcv_pkg::EXP_W,
   parameter int DOUT_W   = gfp8_bcv_pkg::DOUT_W,
   parameter int MAC_LAT  = 2,
   parameter int LEN_W    = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_cmd_valid,
   output logic                         o_cmd_ready,
   input  logic [LEN_W-1:0]             i_cmd_len,
   input  logic [EXP_W-1:0]             i_cmd_exp_a,
   input  logic [EXP_W-1:0]             i_cmd_exp_b,
   input  logic                         i_op_valid,
   output logic                         o_op_ready,
   input  logic [NUM_MULT*MANT_W-1:0]   i_op_a,
   input  logic [NUM_MULT*MANT_W-1:0]   i_op_b,
   output logic [NUM_MULT*MANT_W-1:0]   o_mac_din_a,
   output logic [NUM_MULT*MANT_W-1:0]   o_mac_din_b,
   output logic                         o_mac_load,
   output logic                         o_mac_ce,
   input  logic [DOUT_W-1:0]            i_mac_dout,
   output logic                         o_res_valid,
   input  logic                         i_res_ready,
   output logic [DOUT_W-1:0]            o_res_mant,
   output logic [EXP_W+1:0]             o_res_exp,
   output logic                         o_busy
);
   import gfp8_bcv_pkg::*;

   localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   seq_state_t              state, state_nxt;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        beat_cnt;
   logic [DRN_W-1:0]        drain_cnt;
   logic signed [EXP_W+1:0] exp_sum;
   logic [EXP_W+1:0]        exp_calc;
   gfp8_res_t               res_q;
   logic                    res_valid;
   logic                    last_beat;
   logic                    drain_end;

   // Combined block exponent, biases removed; widened by two bits so it stays signed-safe.
   always_comb begin
      exp_calc = {2'b00, i_cmd_exp_a} + {2'b00, i_cmd_exp_b} - (EXP_W+2)'(2*EXP_BIAS);
   end

   assign last_beat = (beat_cnt == len_q - LEN_W'(1));
   assign drain_end = (drain_cnt == DRN_W'(MAC_LAT-1));

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state and handshake/enable outputs.
   always_comb begin
      state_nxt   = state;
      o_cmd_ready = 1'b0;
      o_op_ready  = 1'b0;
      o_mac_ce    = 1'b1;
      o_busy      = 1'b1;
      case (state)
         IDLE: begin
            o_cmd_ready = 1'b1;
            o_mac_ce    = 1'b0;
            o_busy      = 1'b0;
            if (i_cmd_valid)
               state_nxt = (i_cmd_len == '0) ? DONE : RUN;
         end
         RUN: begin
            o_op_ready = 1'b1;
            if (i_op_valid && last_beat) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_end) state_nxt = DONE;
         end
         DONE: begin
            if (i_res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: MAC feed registers, counters and the held result. MAC inputs default to
   // zero every cycle so bubbles and drain cycles add nothing to the accumulator.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         len_q       <= '0;
         beat_cnt    <= '0;
         drain_cnt   <= '0;
         exp_sum     <= '0;
         res_q       <= '0;
         res_valid   <= 1'b0;
         o_mac_din_a <= '0;
         o_mac_din_b <= '0;
         o_mac_load  <= 1'b0;
      end else begin
         o_mac_din_a <= '0;
         o_mac_din_b <= '0;
         o_mac_load  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_cmd_valid) begin
                  len_q     <= i_cmd_len;
                  exp_sum   <= exp_calc;
                  beat_cnt  <= '0;
                  drain_cnt <= '0;
                  if (i_cmd_len == '0) begin
                     res_q.mant <= '0;
                     res_q.exp  <= exp_calc;
                     res_valid  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (i_op_valid) begin
                  o_mac_din_a <= i_op_a;
                  o_mac_din_b <= i_op_b;
                  o_mac_load  <= (beat_cnt == '0);
                  beat_cnt    <= beat_cnt + LEN_W'(1);
                  drain_cnt   <= '0;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + DRN_W'(1);
               if (drain_end) begin
                  res_q.mant <= i_mac_dout;
                  res_q.exp  <= exp_sum;
                  res_valid  <= 1'b1;
               end
            end
            DONE: begin
               if (i_res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_res_valid = res_valid;
   assign o_res_mant  = res_q.mant;
   assign o_res_exp   = res_q.exp;

endmodule

// File: tb/tb_gfp8_dot_sequencer.sv
// Randomized bench for gfp8_dot_sequencer with an accumulate-mode MAC model behind it.
module tb_gfp8_dot_sequencer;

   localparam int NUM_MULT = 32;
   localparam int MANT_W   = 8;
   localparam int EXP_W    = 5;
   localparam int DOUT_W   = 48;
   localparam int MAC_LAT  = 2;
   localparam int LEN_W    = 8;
   localparam int VW       = NUM_MULT*MANT_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready;
   logic [LEN_W-1:0]  cmd_len;
   logic [EXP_W-1:0]  cmd_exp_a, cmd_exp_b;
   logic              op_valid, op_ready;
   logic [VW-1:0]     op_a, op_b, din_a, din_b;
   logic              mac_load, mac_ce;
   logic [DOUT_W-1:0] mac_dout;
   logic              res_valid, res_ready;
   logic [DOUT_W-1:0] res_mant;
   logic [EXP_W+1:0]  res_exp;
   logic              busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gfp8_dot_sequencer #(
      .NUM_MULT(NUM_MULT), .MANT_W(MANT_W), .EXP_W(EXP_W),
      .DOUT_W(DOUT_W), .MAC_LAT(MAC_LAT), .LEN_W(LEN_W)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_len(cmd_len),
      .i_cmd_exp_a(cmd_exp_a), .i_cmd_exp_b(cmd_exp_b),
      .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_a(op_a), .i_op_b(op_b),
      .o_mac_din_a(din_a), .o_mac_din_b(din_b), .o_mac_load(mac_load), .o_mac_ce(mac_ce),
      .i_mac_dout(mac_dout),
      .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_mant(res_mant), .o_res_exp(res_exp), .o_busy(busy)
   );

   // Signed dot product of one beat across all lanes.
   function automatic longint dotp(input logic [VW-1:0] a, input logic [VW-1:0] b);
      longint s = 0;
      for (int i = 0; i < NUM_MULT; i++)
         s += longint'($signed(a[i*MANT_W +: MANT_W])) * longint'($signed(b[i*MANT_W +: MANT_W]));
      return s;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < NUM_MULT; i++) v[i*MANT_W +: MANT_W] = MANT_W'($urandom);
      return v;
   endfunction

   function automatic logic [VW-1:0] fill_vec(input int val);
      logic [VW-1:0] v;
      for (int i = 0; i < NUM_MULT; i++) v[i*MANT_W +: MANT_W] = MANT_W'(val);
      return v;
   endfunction

   // External MAC: accumulator register after the sequencer's input register, so a beat
   // on din shows up on dout MAC_LAT cycles later counting the din cycle.
   logic signed [DOUT_W-1:0] mac_acc;
   always @(posedge clk) begin
      if (rst)         mac_acc <= '0;
      else if (mac_ce) mac_acc <= DOUT_W'(mac_load ? dotp(din_a, din_b)
                                                   : longint'(mac_acc) + dotp(din_a, din_b));
   end
   assign mac_dout = mac_acc;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One full command. mode: 0 random, 1 a=1/b=2, 2 lane0 -128*127, 3 a=1/b=1.
   // bub: 0 none, 1 random, 2 alternate. hold: cycles to keep res_ready low.
   task automatic run_cmd(input int len, input int ea, input int eb, input int mode,
                          input int bub, input int hold);
      logic [VW-1:0] a, b;
      longint exp_m = 0;
      int exp_e, acc_cyc, n, to;
      bit fired;
      exp_e = ea + eb - 30;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
      cmd_exp_a = EXP_W'(ea);
      cmd_exp_b = EXP_W'(eb);
      to = 0;
      while (!cmd_ready && to < 50) begin @(negedge clk); to++; end
      chk("cmd_ready_wait", longint'(to < 50), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      acc_cyc = cyc;
      n = 0;
      to = 0;
      while (n < len && to < 200) begin
         a = '0; b = '0;
         case (mode)
            1: begin a = fill_vec(1); b = fill_vec(2); end
            2: begin a[MANT_W-1:0] = 8'h80; b[MANT_W-1:0] = 8'h7f; end
            3: begin a = fill_vec(1); b = fill_vec(1); end
            default: begin a = rand_vec(); b = rand_vec(); end
         endcase
         op_a = a;
         op_b = b;
         op_valid = (bub == 1) ? 1'($urandom_range(0, 1)) : (bub == 2) ? ((to % 2) == 0) : 1'b1;
         fired = op_valid && op_ready;
         if (fired) exp_m += dotp(a, b);
         @(negedge clk);
         if (fired) begin
            chk("mac_load", longint'(mac_load), longint'(n == 0));
            chk("mac_din", longint'(din_a == a && din_b == b), 1);
            n++;
         end else begin
            chk("bubble_zero", longint'(din_a == '0 && din_b == '0 && !mac_load), 1);
         end
         to++;
      end
      op_valid = 1'b0;
      to = 0;
      while (!res_valid && to < 100) begin @(negedge clk); to++; end
      chk("res_valid", longint'(res_valid), 1);
      if (bub == 0) chk("latency", longint'(cyc - acc_cyc), (len == 0) ? 0 : len + MAC_LAT);
      chk("res_mant", longint'($signed(res_mant)), exp_m);
      chk("res_exp", longint'($signed(res_exp)), exp_e);
      chk("cmd_ready_done", longint'(cmd_ready), 0);
      for (int k = 0; k < hold; k++) begin
         op_valid = 1'b1;
         op_a = rand_vec();
         op_b = rand_vec();
         @(negedge clk);
         chk("hold_valid", longint'(res_valid), 1);
         chk("hold_mant", longint'($signed(res_mant)), exp_m);
         chk("hold_exp", longint'($signed(res_exp)), exp_e);
         chk("hold_cmd_ready", longint'(cmd_ready), 0);
         chk("hold_op_ready", longint'(op_ready), 0);
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_cleared", longint'(res_valid), 0);
      chk("idle_cmd_ready", longint'(cmd_ready), 1);
      chk("idle_ce", longint'(mac_ce), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_len = '0; cmd_exp_a = '0; cmd_exp_b = '0;
      op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_res_valid", longint'(res_valid), 0);
      chk("rst_res_mant", longint'(res_mant), 0);
      chk("rst_res_exp", longint'(res_exp), 0);
      chk("rst_din", longint'(din_a == '0 && din_b == '0), 1);
      chk("rst_load", longint'(mac_load), 0);
      chk("rst_ce", longint'(mac_ce), 0);
      chk("rst_cmd_ready", longint'(cmd_ready), 1);
      chk("rst_op_ready", longint'(op_ready), 0);
      chk("rst_busy", longint'(busy), 0);
      rst = 1'b0;
      @(negedge clk);

      run_cmd(1, 15, 15, 1, 0, 0);     // 32 lanes * 1*2 = 64, exponent 0
      run_cmd(4, 15, 15, 2, 2, 0);     // 4 * (-128*127) = -65024 with bubbles
      run_cmd(2, 16, 14, 3, 0, 0);     // back-to-back: 64
      run_cmd(3, 10, 12, 3, 0, 0);     // then 96, fresh load
      run_cmd(0, 20, 3, 0, 0, 0);      // empty: mant 0, exp -7
      run_cmd(2, 31, 31, 0, 0, 10);    // long hold on result

      // Reset in the middle of a 4-beat run.
      cmd_valid = 1'b1; cmd_len = LEN_W'(4); cmd_exp_a = 5'd15; cmd_exp_b = 5'd15;
      @(negedge clk);
      cmd_valid = 1'b0;
      op_a = fill_vec(3); op_b = fill_vec(3); op_valid = 1'b1;
      repeat (2) @(negedge clk);
      op_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_res_valid", longint'(res_valid), 0);
      chk("abort_cmd_ready", longint'(cmd_ready), 1);
      chk("abort_busy", longint'(busy), 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_no_result", longint'(res_valid), 0);
      end
      run_cmd(1, 15, 15, 0, 0, 0);

      for (int t = 0; t < 10; t++)
         run_cmd($urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 31), 0,
                 $urandom_range(0, 1), $urandom_range(0, 3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
